// File: rtl/fsl_frame_engine.sv
// FSL frame engine: buffers a header + L data words, then emits header echo and transformed words.
// Optional checksum trailer enabled by defining FSL_CHECKSUM_EN.
module fsl_frame_engine #(
  parameter int C_FSL_DWIDTH = 32,
  parameter int C_DEPTH      = 8,
  parameter int C_LEN_BITS   = 3
) (
  input  logic                    FSL_Clk,
  input  logic                    FSL_Rst,
  output logic                    FSL_S_Clk,
  input  logic [0:C_FSL_DWIDTH-1] FSL_S_Data,
  input  logic                    FSL_S_Control,
  input  logic                    FSL_S_Exists,
  output logic                    FSL_S_Read,
  output logic                    FSL_M_Clk,
  output logic [0:C_FSL_DWIDTH-1] FSL_M_Data,
  output logic                    FSL_M_Control,
  output logic                    FSL_M_Write,
  input  logic                    FSL_M_Full,
  output logic                    frame_done,
  output logic [15:0]             drop_cnt
);
  localparam int W  = C_FSL_DWIDTH;
  localparam int LB = C_LEN_BITS;
  localparam logic [LB-1:0] ONE = LB'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ECHO, S_DRAIN
`ifdef FSL_CHECKSUM_EN
    , S_TRAILER
`endif
  } state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_buf [C_DEPTH];
  logic [W-1:0]    r_hdr;
  logic [3:0]      r_op;
  logic [LB-1:0]   r_len, r_wr_ptr, r_rd_idx;
  logic [15:0]     r_drop;
  logic            r_done;
`ifdef FSL_CHECKSUM_EN
  logic [W-1:0]    r_csum;
`endif

  // Internal vectors are little-endian; FSL bit 0 (MSB) lands on [W-1].
  logic [W-1:0]    w_sdata, w_mdata, w_word, w_xf;
  logic [LB-1:0]   w_len_m1, w_ridx;
  logic            w_mctl, w_last_wr, w_last_rd;
  logic [15:0]     w_drop_add;
  logic [16:0]     w_drop_sum;

  assign FSL_S_Clk     = FSL_Clk;
  assign FSL_M_Clk     = FSL_Clk;
  assign w_sdata       = FSL_S_Data;
  assign FSL_M_Data    = w_mdata;
  assign FSL_M_Control = w_mctl;
  assign frame_done    = r_done;
  assign drop_cnt      = r_drop;

  // L=0 encodes C_DEPTH; modulo arithmetic on LB bits handles that for free.
  assign w_len_m1  = r_len - ONE;
  assign w_last_wr = (r_wr_ptr == w_len_m1);
  assign w_last_rd = (r_rd_idx == w_len_m1);
  assign w_ridx    = (r_op == 4'd1) ? (w_len_m1 - r_rd_idx) : r_rd_idx;
  assign w_word    = r_buf[w_ridx];

  always_comb begin
    w_xf = w_word;
    case (r_op)
      4'd2: w_xf = ~w_word;
      4'd3: for (int i = 0; i < W/8; i++) w_xf[8*i +: 8] = w_word[W-8-8*i +: 8];
      default: w_xf = w_word;
    endcase
  end

  always_comb begin
    w_drop_add = (r_state == S_IDLE) ? 16'd1 : {{(16-LB){1'b0}}, r_wr_ptr};
    w_drop_sum = {1'b0, r_drop} + {1'b0, w_drop_add};
  end

  always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
    if (FSL_Rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    FSL_S_Read  = 1'b0;
    FSL_M_Write = 1'b0;
    w_mdata     = '0;
    w_mctl      = 1'b0;
    case (r_state)
      S_IDLE: begin
        FSL_S_Read = FSL_S_Exists;
        if (FSL_S_Exists && FSL_S_Control) w_next = S_LOAD;
      end
      S_LOAD: begin
        FSL_S_Read = FSL_S_Exists;
        if (FSL_S_Exists && !FSL_S_Control && w_last_wr) w_next = S_ECHO;
      end
      S_ECHO: begin
        FSL_M_Write = !FSL_M_Full;
        w_mdata     = r_hdr;
        w_mctl      = 1'b1;
        if (!FSL_M_Full) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        FSL_M_Write = !FSL_M_Full;
        w_mdata     = w_xf;
`ifdef FSL_CHECKSUM_EN
        if (!FSL_M_Full && w_last_rd) w_next = S_TRAILER;
`else
        if (!FSL_M_Full && w_last_rd) w_next = S_IDLE;
`endif
      end
`ifdef FSL_CHECKSUM_EN
      S_TRAILER: begin
        FSL_M_Write = !FSL_M_Full;
        w_mdata     = r_csum;
        w_mctl      = 1'b1;
        if (!FSL_M_Full) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Frame storage needs no reset: pointers gate every read.
  always_ff @(posedge FSL_Clk) begin
    if (r_state == S_LOAD && FSL_S_Exists && !FSL_S_Control) r_buf[r_wr_ptr] <= w_sdata;
  end

  always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
    if (FSL_Rst) begin
      r_hdr    <= '0;
      r_op     <= '0;
      r_len    <= '0;
      r_wr_ptr <= '0;
      r_rd_idx <= '0;
      r_drop   <= '0;
      r_done   <= 1'b0;
`ifdef FSL_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_LOAD: if (FSL_S_Exists) begin
          if (FSL_S_Control) begin
            if (r_state == S_LOAD) r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            r_hdr    <= w_sdata;
            r_op     <= w_sdata[W-1 -: 4];
            r_len    <= w_sdata[LB-1:0];
            r_wr_ptr <= '0;
          end else if (r_state == S_IDLE) begin
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
          end else begin
            r_wr_ptr <= w_last_wr ? '0 : r_wr_ptr + ONE;
          end
        end
        S_ECHO: if (!FSL_M_Full) begin
          r_rd_idx <= '0;
`ifdef FSL_CHECKSUM_EN
          r_csum   <= '0;
`endif
        end
        S_DRAIN: if (!FSL_M_Full) begin
          r_rd_idx <= r_rd_idx + ONE;
`ifdef FSL_CHECKSUM_EN
          r_csum   <= r_csum + w_xf;
`else
          r_done   <= w_last_rd;
`endif
        end
`ifdef FSL_CHECKSUM_EN
        S_TRAILER: if (!FSL_M_Full) r_done <= 1'b1;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fsl_frame_engine.sv
// Self-checking bench for fsl_frame_engine: slave FIFO model, master scoreboard, vector table.
module tb_fsl_frame_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_clk, m_clk;
  logic [0:31] s_data;
  logic        s_ctl, s_exists, s_read;
  logic [0:31] m_data;
  logic        m_ctl, m_write, m_full, done;
  logic [15:0] drop;
  logic [31:0] md;

  always #5 clk = ~clk;
  assign md = m_data;

  fsl_frame_engine #(.C_FSL_DWIDTH(32), .C_DEPTH(8), .C_LEN_BITS(3)) dut (
    .FSL_Clk(clk), .FSL_Rst(rst), .FSL_S_Clk(s_clk),
    .FSL_S_Data(s_data), .FSL_S_Control(s_ctl), .FSL_S_Exists(s_exists), .FSL_S_Read(s_read),
    .FSL_M_Clk(m_clk), .FSL_M_Data(m_data), .FSL_M_Control(m_ctl), .FSL_M_Write(m_write),
    .FSL_M_Full(m_full), .frame_done(done), .drop_cnt(drop));

  typedef struct {
    logic [31:0]      hdr;
    int               n;
    logic [7:0][31:0] din;
    logic [7:0][31:0] dout;
    logic [31:0]      csum;
  } vec_t;

  logic [32:0] in_q[$];
  logic [32:0] exp_q[$];
  int          checks = 0, errors = 0, done_cnt = 0, exp_done = 0, full_mode = 0;
  logic [15:0] exp_drop = 0;
  vec_t        vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave FIFO model and back-pressure driver; inputs change 1 time unit after the edge.
  initial begin
    logic take;
    s_exists = 0; s_data = '0; s_ctl = 0; m_full = 0;
    forever begin
      @(negedge clk);
      take = s_read;
      @(posedge clk);
      #1;
      if (take && in_q.size() > 0) void'(in_q.pop_front());
      if (in_q.size() > 0) begin
        s_exists = 1'b1; s_ctl = in_q[0][32]; s_data = in_q[0][31:0];
      end else begin
        s_exists = 1'b0; s_ctl = 1'b0; s_data = '0;
      end
      case (full_mode)
        1:       m_full = 1'($urandom_range(0, 1));
        2:       m_full = 1'b1;
        default: m_full = 1'b0;
      endcase
    end
  end

  // Master scoreboard
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (m_full) chk("write_while_full", {31'd0, m_write}, 32'd0);
      if (m_write) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got ctl=%0d data=%h expected no write", m_ctl, md);
        end else begin
          e = exp_q.pop_front();
          chk("out_ctl", {31'd0, m_ctl}, {31'd0, e[32]});
          chk("out_data", md, e[31:0]);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_in(input logic c, input logic [31:0] d);
    in_q.push_back({c, d});
  endtask

  task automatic expect_out(input logic c, input logic [31:0] d);
    exp_q.push_back({c, d});
  endtask

  task automatic expect_csum(input logic [31:0] c);
`ifdef FSL_CHECKSUM_EN
    expect_out(1'b1, c);
`else
    if (c === 32'hx) expect_out(1'b1, c);
`endif
  endtask

  task automatic run_vec(input vec_t v);
    push_in(1'b1, v.hdr);
    for (int i = 0; i < v.n; i++) push_in(1'b0, v.din[i]);
    expect_out(1'b1, v.hdr);
    for (int i = 0; i < v.n; i++) expect_out(1'b0, v.dout[i]);
    expect_csum(v.csum);
    exp_done++;
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((exp_q.size() > 0 || in_q.size() > 0) && k < 400) begin
      @(posedge clk); k++;
    end
    repeat (3) @(posedge clk);
    chk({nm, "_timeout"}, {31'd0, k >= 400}, 32'd0);
    chk({nm, "_leftover"}, exp_q.size(), 32'd0);
    chk({nm, "_frame_done"}, done_cnt, exp_done);
    chk({nm, "_drop_cnt"}, {16'd0, drop}, {16'd0, exp_drop});
    exp_q.delete();
  endtask

  initial begin
    int k;
    // Vector table: opcode, length boundary (L=0 -> 8) and transform cases.
    vt[0].hdr = 32'h1000_0003; vt[0].n = 3; vt[0].csum = 32'd6;
    for (int i = 0; i < 3; i++) begin vt[0].din[i] = i + 1; vt[0].dout[i] = 3 - i; end
    vt[1].hdr = 32'h2000_0000; vt[1].n = 8; vt[1].csum = 32'hFFFF_FFDC;
    for (int i = 0; i < 8; i++) begin vt[1].din[i] = i; vt[1].dout[i] = 32'hFFFF_FFFF - i; end
    vt[2].hdr = 32'h3000_0001; vt[2].n = 1; vt[2].csum = 32'h4433_2211;
    vt[2].din[0] = 32'h1122_3344; vt[2].dout[0] = 32'h4433_2211;
    vt[3].hdr = 32'h5000_0002; vt[3].n = 2; vt[3].csum = 32'h0000_0165;
    vt[3].din[0] = 32'hAA; vt[3].din[1] = 32'hBB; vt[3].dout[0] = 32'hAA; vt[3].dout[1] = 32'hBB;
    vt[4].hdr = 32'h0000_0002; vt[4].n = 2; vt[4].csum = 32'hDEAD_BEF0;
    vt[4].din[0] = 32'hDEAD_BEEF; vt[4].din[1] = 32'h1; vt[4].dout[0] = 32'hDEAD_BEEF; vt[4].dout[1] = 32'h1;
    vt[5].hdr = 32'h1000_0000; vt[5].n = 8; vt[5].csum = 32'h0000_009C;
    for (int i = 0; i < 8; i++) begin vt[5].din[i] = 32'h10 + i; vt[5].dout[i] = 32'h17 - i; end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_write", {31'd0, m_write}, 32'd0);
    chk("rst_s_read", {31'd0, s_read}, 32'd0);
    chk("rst_m_data", md, 32'd0);
    chk("rst_m_ctl", {31'd0, m_ctl}, 32'd0);
    chk("rst_frame_done", {31'd0, done}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop}, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      run_vec(vt[t]);
      wait_drain($sformatf("vec%0d", t));
    end

    // Stray data words in IDLE are dropped
    push_in(0, 32'd5); push_in(0, 32'd6); push_in(1, 32'h0000_0001); push_in(0, 32'd9);
    expect_out(1, 32'h0000_0001); expect_out(0, 32'd9); expect_csum(32'd9);
    exp_drop += 2; exp_done++;
    wait_drain("idle_drop");

    // New header mid-LOAD aborts the partial frame
    push_in(1, 32'h0000_0004); push_in(0, 32'hA); push_in(0, 32'hB);
    push_in(1, 32'h0000_0001); push_in(0, 32'hC);
    expect_out(1, 32'h0000_0001); expect_out(0, 32'hC); expect_csum(32'hC);
    exp_drop += 2; exp_done++;
    wait_drain("load_abort");

    // Random back-pressure must not lose or duplicate words
    full_mode = 1;
    run_vec(vt[0]);
    wait_drain("backpressure");
    full_mode = 0;

    // Reset while stalled in DRAIN
    push_in(1, 32'h1000_0003); push_in(0, 32'd1); push_in(0, 32'd2); push_in(0, 32'd3);
    expect_out(1, 32'h1000_0003); expect_out(0, 32'd3);
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin @(posedge clk); k++; end
    full_mode = 2;
    chk("mid_drain_timeout", {31'd0, k >= 200}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_write", {31'd0, m_write}, 32'd0);
    chk("midrst_m_data", md, 32'd0);
    chk("midrst_m_ctl", {31'd0, m_ctl}, 32'd0);
    chk("midrst_drop_cnt", {16'd0, drop}, 32'd0);
    @(negedge clk) rst = 1'b0;
    full_mode = 0; exp_drop = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle_data", md, 32'd0);
    chk("post_rst_idle_write", {31'd0, m_write}, 32'd0);
    run_vec(vt[0]);
    wait_drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsl_frame_engine.md
Name: fsl_frame_engine

Overview:
- Parametrised FSL slave/master stream processor; successor to the fixed-width test_fsl peripheral.
- Accepts framed packets on the FSL slave port: a header word (FSL_S_Control=1) followed by N data words.
- Buffers each frame internally, applies a header-selected transform, and emits header echo + transformed words (+ optional checksum) on the FSL master port.
- Sits between MicroBlaze FSL channels and accelerator cores.

Parameters:
- C_FSL_DWIDTH, 32, data width of FSL_S_Data/FSL_M_Data, minimum 8, multiple of 8.
- C_DEPTH, 8, frame buffer depth in words, power of 2, range 2..256.
- C_LEN_BITS, 3, log2(C_DEPTH); width of the header length field.

Ports:
- FSL_Clk  in  1  single clock for all logic.
- FSL_Rst  in  1  asynchronous, active-high reset.
- FSL_S_Clk  out  1  tied to FSL_Clk.
- FSL_S_Data  in  [0:C_FSL_DWIDTH-1]  slave data, bit 0 = MSB.
- FSL_S_Control  in  1  1 = header word.
- FSL_S_Exists  in  1  slave FIFO non-empty.
- FSL_S_Read  out  1  pops slave FIFO this cycle.
- FSL_M_Clk  out  1  tied to FSL_Clk.
- FSL_M_Data  out  [0:C_FSL_DWIDTH-1]  master data.
- FSL_M_Control  out  1  1 on header echo and trailer words.
- FSL_M_Write  out  1  pushes master FIFO this cycle.
- FSL_M_Full  in  1  master FIFO full.
- frame_done  out  1  one-cycle pulse after the last output word of a frame.
- drop_cnt  out  16  saturating count of discarded or aborted input words.

Behaviour:
- Header fields:
  - Opcode = FSL_S_Data[0:3].
  - Length L = FSL_S_Data[C_FSL_DWIDTH-C_LEN_BITS : C_FSL_DWIDTH-1].
  - L=0 means C_DEPTH words, so a frame can never overflow the buffer.
- Opcodes:
  - 0 = pass.
  - 1 = reverse word order.
  - 2 = bitwise invert.
  - 3 = byte-reverse within each word.
  - 4..15 = pass; the header is still echoed unchanged.
- Reset (asynchronous, any state): state=IDLE, all pointers 0, drop_cnt=0, frame_done=0, FSL_M_Write=0, FSL_S_Read=0, FSL_M_Data=0, FSL_M_Control=0, checksum accumulator 0.
- FSL_S_Read is combinational: FSL_S_Exists && state in {IDLE, LOAD}. A word is consumed in the cycle FSL_S_Read=1.
- FSL_M_Write is combinational: (state in {ECHO, DRAIN, TRAILER}) && !FSL_M_Full. FSL_M_Data and FSL_M_Control are driven from registers/buffer and are stable while FSL_M_Full holds the write off.
- States:
  - IDLE: a control word latches opcode and L and goes to LOAD. A data word (control=0) is popped and dropped, drop_cnt+1.
  - LOAD: each popped data word is written to buf[wr_ptr], wr_ptr+1. After the L-th word, go to ECHO. A control word arriving in LOAD aborts the frame: drop_cnt += words already loaded, the new header is latched, wr_ptr=0, stay in LOAD.
  - ECHO: output the latched header with control=1. On write, go to DRAIN.
  - DRAIN: output transform(buf[rd_idx]) with control=0. rd_idx counts 0..L-1; opcode 1 reads index L-1-rd_idx. After the last write, go to TRAILER if FSL_CHECKSUM_EN is defined, else go to IDLE and pulse frame_done.
  - TRAILER: output the checksum with control=1. On write, go to IDLE and pulse frame_done.
- Slave input is not read during ECHO, DRAIN or TRAILER (no overlap); throughput is one word per cycle when not back-pressured.
- Latency: the header echo appears on FSL_M_Write 1 cycle after the L-th data word is read.
- drop_cnt saturates at 16'hFFFF.
- FSL_M_Full asserted mid-DRAIN stalls rd_idx; no word is lost or duplicated.

Optional Feature:
- Macro: FSL_CHECKSUM_EN.
- Defined:
  - After the data, one trailer word is emitted with FSL_M_Control=1.
  - Value = sum modulo 2^C_FSL_DWIDTH of all transformed data words in the frame.
  - The accumulator clears at ECHO.
- Undefined: no TRAILER state and no accumulator; frame_done pulses after the last DRAIN word.

Test Plan (C_FSL_DWIDTH=32, C_DEPTH=8):
1. Header 32'h1000_0003 (ctl=1), then 1, 2, 3 -> master emits 32'h1000_0003 (ctl=1), 3, 2, 1; with FSL_CHECKSUM_EN, trailer 6 (ctl=1); one frame_done pulse.
2. Header 32'h2000_0000 (L=0 means 8), then data 0..7 -> 8 outputs 32'hFFFF_FFFF..32'hFFFF_FFF8 in order; checksum 32'hFFFF_FFDC.
3. Header 32'h3000_0001, then 32'h1122_3344 -> output 32'h4433_2211.
4. Data words 5, 6 with ctl=0 while IDLE, then header 32'h0000_0001 and word 9 -> drop_cnt=2; output header, then 9.
5. Header 32'h0000_0004, words A, B, then new header 32'h0000_0001 and word C -> drop_cnt=2; output only 32'h0000_0001, C.
6. Case 1 with FSL_M_Full toggled randomly, plus FSL_Rst pulsed mid-DRAIN in a second run -> first run output sequence identical to case 1; after reset, outputs idle at 0 and the next frame processes normally.
